key_debounce: RTL and testbench
===============================

// Module: key_debounce
// PURPOSE
//  Multi-channel pushbutton conditioner for the talking calculator front end.
//  Synchronises raw board KEY/SW inputs into clk and filters contact bounce.
//  Presents a clean, active-high "pressed" level per channel.
//  Sits directly upstream of edge_capture, which turns each clean level into a one-cycle press pulse.
// PARAMETERS
//  NUM_KEYS         4          number of independent input channels
//  DEBOUNCE_CYCLES  1_000_000  consecutive disagreeing cycles before a level change is accepted (>=2; 20 ms @ 50 MHz)
//  ACTIVE_LOW       1          1: raw inputs are active-low (DE1 KEY) and are inverted; 0: passed as-is
// PORTS
//  clk        in   1         system clock, all state on posedge
//  rst        in   1         asynchronous, active-high reset
//  raw_in     in   NUM_KEYS  raw asynchronous button/switch levels
//  clean_out  out  NUM_KEYS  debounced level, 1 = pressed/asserted
//  settling   out  NUM_KEYS  1 while the channel is counting a candidate change
// BEHAVIOUR
//  - Reset (async, rst=1):
//    - both synchroniser flops <= inactive raw level (1 if ACTIVE_LOW else 0)
//    - clean_out <= 0, settling <= 0, all counters <= 0
//    - reset mid-count discards the pending change; after release the channel re-qualifies from scratch
//  - Synchroniser: two flops per channel, s = q2 ^ ACTIVE_LOW (polarity-corrected).
//  - Per channel, 2-state FSM {ST_STABLE, ST_SETTLING}, counter cnt of width $clog2(DEBOUNCE_CYCLES):
//    - ST_STABLE:   s==clean_out -> stay, cnt=0
//                   s!=clean_out -> ST_SETTLING, cnt<=1
//    - ST_SETTLING: s==clean_out -> ST_STABLE, cnt<=0 (bounce rejected, clean_out unchanged)
//                   s!=clean_out and cnt<DEBOUNCE_CYCLES-1 -> cnt<=cnt+1
//                   s!=clean_out and cnt==DEBOUNCE_CYCLES-1 -> clean_out<=s, cnt<=0, ST_STABLE
//    - settling = (state==ST_SETTLING), registered with state
//  - Latency: raw change set up before edge k -> q2 updates at edge k+1 -> clean_out toggles at edge k+1+DEBOUNCE_CYCLES
//  - Any single-cycle agreement during settling fully restarts the count; no partial credit.
//  - Channels are fully independent; simultaneous changes on several channels each resolve on their own schedule.
//  - Counter never wraps: it is cleared on accept or reject, and its width covers DEBOUNCE_CYCLES-1.
//  - clean_out is glitch-free (direct flop output) and safe to feed edge_capture.in_sig.
// STRUCTURE
//  - Shared package calc_pkg:
//    - typedef enum logic {ST_STABLE, ST_SETTLING} db_state_t
//    - localparam CLK_HZ = 50_000_000
//    - default DEBOUNCE_CYCLES derivation (CLK_HZ/50)
//  - Sub-module debounce_channel (one channel: synchroniser + FSM + counter)
//    - instantiated NUM_KEYS times via a generate loop
//    - key_debounce itself holds only the polarity handling and port fan-out
// TESTING (DEBOUNCE_CYCLES=4, NUM_KEYS=4, ACTIVE_LOW=1, clk period 2)
//  1. Assert rst with raw_in=4'hF, release -> clean_out=0, settling=0; stays 0 for 20 cycles.
//  2. raw_in[0]: 1->0 held, set up before edge k -> settling[0]=1 from edge k+2; clean_out[0]=1 at edge k+5, settling[0]=0.
//  3. raw_in[1] low 3 cycles, high 1, low 3 (bounce) -> clean_out[1] stays 0; then held low -> clean_out[1]=1 exactly 5 edges after the final fall.
//  4. Release after press: raw_in[0] 0->1 held -> clean_out[0] 1->0 5 edges later; 1-cycle low glitch while pressed -> no change.
//  5. raw_in=4'h0 all at once -> all four clean_out bits rise on the same edge; then stagger releases -> independent falls.
//  6. rst pulsed while settling[2]=1 with cnt=2 -> clean_out[2]=0 immediately; after release a full 5-edge qualification is required.
//  - Cover: tie clean_out[0] to edge_capture; check exactly one out_sig pulse per qualified press and none per rejected bounce.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared types and constants for the talking-calculator front end.
// Holds the debounce FSM state type and the default 20 ms qualification window.
package calc_pkg;

    typedef enum logic {
        ST_STABLE   = 1'b0,
        ST_SETTLING = 1'b1
    } db_state_t;

    localparam int CLK_HZ = 50_000_000;

    // 20 ms of contact bounce at CLK_HZ
    localparam int DEFAULT_DEBOUNCE_CYCLES = CLK_HZ / 50;

endpackage

// File: rtl/key_debounce_channel.sv
// One debounce channel: 2-flop synchroniser, stable/settling FSM and run counter.
// clean toggles DEBOUNCE_CYCLES edges after the synchronised level first disagrees.
module debounce_channel
    import calc_pkg::*;
#(
    parameter int   DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter logic IDLE_LEVEL      = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic clean,
    output logic settling
);

    localparam int              CW       = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          q1;
    logic          q2;
    logic          s;
    db_state_t     state;
    logic [CW-1:0] cnt;

    // Polarity-corrected: 1 means pressed/asserted.
    assign s        = q2 ^ IDLE_LEVEL;
    assign settling = (state == ST_SETTLING);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q1    <= IDLE_LEVEL;
            q2    <= IDLE_LEVEL;
            state <= ST_STABLE;
            cnt   <= '0;
            clean <= 1'b0;
        end else begin
            q1 <= raw;
            q2 <= q1;
            case (state)
                ST_STABLE: begin
                    if (s != clean) begin
                        state <= ST_SETTLING;
                        cnt   <= CW'(1);
                    end else begin
                        cnt   <= '0;
                    end
                end
                ST_SETTLING: begin
                    // Any agreement discards the whole run; no partial credit.
                    if (s == clean) begin
                        state <= ST_STABLE;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        clean <= s;
                        state <= ST_STABLE;
                        cnt   <= '0;
                    end else begin
                        cnt   <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= ST_STABLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/key_debounce.sv
// Multi-channel pushbutton conditioner: synchronises and debounces raw KEY/SW levels.
// Each channel resolves independently; clean_out is a direct flop output, safe for edge_capture.
module key_debounce
    import calc_pkg::*;
#(
    parameter int NUM_KEYS        = 4,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter bit ACTIVE_LOW      = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_KEYS-1:0] raw_in,
    output logic [NUM_KEYS-1:0] clean_out,
    output logic [NUM_KEYS-1:0] settling
);

    // Level the raw pin rests at when nothing is pressed.
    localparam logic IDLE_LEVEL = ACTIVE_LOW ? 1'b1 : 1'b0;

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_chan
        debounce_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .IDLE_LEVEL      (IDLE_LEVEL)
        ) u_chan (
            .clk      (clk),
            .rst      (rst),
            .raw      (raw_in[i]),
            .clean    (clean_out[i]),
            .settling (settling[i])
        );
    end

endmodule

// File: tb/tb_key_debounce.sv
// Bench for key_debounce: run-length reference model checked every cycle,
// plus hand-timed directed expectations for each scenario.
`timescale 1ns/1ps
module tb_key_debounce;

    localparam int NK = 4;
    localparam int D  = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [NK-1:0] raw_in;
    logic [NK-1:0] clean_out;
    logic [NK-1:0] settling;

    always #1 clk = ~clk;

    key_debounce #(
        .NUM_KEYS        (NK),
        .DEBOUNCE_CYCLES (D),
        .ACTIVE_LOW      (1'b1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .raw_in    (raw_in),
        .clean_out (clean_out),
        .settling  (settling)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [NK-1:0] act, input logic [NK-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Reference model: a level reaches the FSM two edges after it is sampled;
    // the output flips once D consecutive edges have seen it disagree.
    logic [NK-1:0] m_hist0  = '1;
    logic [NK-1:0] m_hist1  = '1;
    logic [NK-1:0] m_press;
    logic [NK-1:0] m_clean  = '0;
    logic [NK-1:0] m_settle = '0;
    int            run [NK] = '{default: 0};

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_hist0  = '1;
            m_hist1  = '1;
            m_clean  = '0;
            m_settle = '0;
            for (int i = 0; i < NK; i++) run[i] = 0;
        end else begin
            m_press = ~m_hist1;
            m_hist1 = m_hist0;
            m_hist0 = raw_in;
            for (int i = 0; i < NK; i++) begin
                if (m_press[i] != m_clean[i]) begin
                    run[i]++;
                    if (run[i] == D) begin
                        m_clean[i] = m_press[i];
                        run[i]     = 0;
                    end
                end else begin
                    run[i] = 0;
                end
                m_settle[i] = (run[i] != 0);
            end
        end
    end

    always @(negedge clk) begin
        check("model_clean", clean_out, m_clean);
        check("model_settling", settling, m_settle);
    end

    // Stand-in for edge_capture on channel 0: one pulse per rising clean level.
    int   pulses0 = 0;
    logic prev0   = 1'b0;
    always @(negedge clk) begin
        if (clean_out[0] && !prev0) pulses0++;
        prev0 = clean_out[0];
    end

    initial begin
        rst    = 1'b1;
        raw_in = 4'hF;
        tick(3);
        rst = 1'b0;

        // 1: idle after reset
        tick(20);
        check("idle_clean", clean_out, 4'h0);
        check("idle_settling", settling, 4'h0);

        // 2: clean press on channel 0, sampled at edge k
        raw_in[0] = 1'b0;
        tick(1);
        tick(1); check("t2_k1_settling", settling, 4'h0);
        tick(1); check("t2_k2_settling", settling, 4'h1);
        tick(2); check("t2_k4_clean", clean_out, 4'h0);
        tick(1); check("t2_k5_clean", clean_out, 4'h1);
                 check("t2_k5_settling", settling, 4'h0);

        // 3: bounce on channel 1, then held; final fall sampled at edge m
        raw_in[1] = 1'b0; tick(3);
        raw_in[1] = 1'b1; tick(1);
        raw_in[1] = 1'b0;
        tick(2); check("t3_m1_bounce_rejected", settling & 4'h2, 4'h0);
        tick(3); check("t3_m4_clean", clean_out, 4'h1);
        tick(1); check("t3_m5_clean", clean_out, 4'h3);

        // 4: one-cycle glitch on a pressed key, then a real release
        raw_in[0] = 1'b1; tick(1);
        raw_in[0] = 1'b0;
        tick(8); check("t4_glitch_ignored", clean_out, 4'h3);
        raw_in[0] = 1'b1;
        tick(5); check("t4_k4_release", clean_out, 4'h3);
        tick(1); check("t4_k5_release", clean_out, 4'h2);
        raw_in = 4'hF;
        tick(8); check("t4_all_released", clean_out, 4'h0);

        // 5: all press together, staggered release
        raw_in = 4'h0;
        tick(5); check("t5_k4_all", clean_out, 4'h0);
        tick(1); check("t5_k5_all", clean_out, 4'hF);
        raw_in[0] = 1'b1; tick(1);
        raw_in[1] = 1'b1; tick(1);
        raw_in[2] = 1'b1; tick(1);
        raw_in[3] = 1'b1; tick(2);
        check("t5_stagger_k4", clean_out, 4'hF);
        tick(1); check("t5_stagger_k5", clean_out, 4'hE);
        tick(1); check("t5_stagger_k6", clean_out, 4'hC);
        tick(1); check("t5_stagger_k7", clean_out, 4'h8);
        tick(1); check("t5_stagger_k8", clean_out, 4'h0);

        // 6: reset while channel 2 is mid-count (cnt=2 after edge k+3)
        tick(4);
        raw_in[2] = 1'b0;
        tick(4); check("t6_settling_before_rst", settling, 4'h4);
        #0.5 rst = 1'b1;
        #0.25;
        check("t6_rst_settling", settling, 4'h0);
        check("t6_rst_clean", clean_out, 4'h0);
        tick(2);
        rst = 1'b0;
        tick(5); check("t6_k4_requalify", clean_out, 4'h0);
        tick(1); check("t6_k5_requalify", clean_out, 4'h4);

        raw_in = 4'hF;
        tick(10);
        check("final_clean", clean_out, 4'h0);
        check("ch0_press_pulses", 4'(pulses0), 4'd2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
